branch_predict_resolve: RTL and testbench



---
 rtl/branch_pkg.sv | 34 +++
 rtl/bht_sat_table.sv | 35 +++
 rtl/branch_predict_resolve.sv | 168 ++++++++++++++++
 tb/tb_branch_predict_resolve.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve / prediction slice.
//   - RISC-V opcode[6:2] values for conditional branches, JAL and JALR
//   - funct3 codes for the six branch conditions
//   - 2-bit saturating counter type with increment/decrement helpers
//   - squash FSM state encoding
package branch_pkg;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] ctr_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } fsm_state_t;

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/bht_sat_table.sv
// Branch history table of 2-bit saturating counters.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset (all entries <- INIT)
//   rd_idx / rd_ctr    combinational read port (old value on same-cycle write)
//   wr_en, wr_idx,     write port: counter at wr_idx saturating-increments when
//   wr_taken           wr_taken is 1, otherwise saturating-decrements
module bht_sat_table
  import branch_pkg::*;
#(
  parameter int   DEPTH = 64,
  parameter ctr_t INIT  = 2'b01,
  parameter int   IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr_t             rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  ctr_t table_q [DEPTH];

  assign rd_ctr = table_q[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= INIT;
    end else if (wr_en) begin
      table_q[wr_idx] <= wr_taken ? sat_inc(table_q[wr_idx]) : sat_dec(table_q[wr_idx]);
    end
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch prediction + EX-stage resolution with registered redirect and
// post-redirect squash window.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   f_pc / f_pred_taken   fetch-side BHT lookup (combinational)
//   e_valid, e_inst,      EX slot: instruction, PC, operands, carried
//   e_pc, e_rs1, e_rs2,   prediction and computed taken target
//   e_pred_taken, e_target
//   redirect, redirect_pc registered flush pulse and refetch address
//   stat_branches,        (only with BRANCH_STATS_EN) counts of active
//   stat_mispredicts      control instructions and mispredicts
// Build option: define BRANCH_STATS_EN to add the statistics counters.
//
// state     | meaning
// ST_RUN    | normal resolve; mispredict raises redirect and enters ST_SQUASH
// ST_SQUASH | wrong-path EX slots ignored; down-counter exits at count 1
module branch_predict_resolve
  import branch_pkg::*;
#(
  parameter int   XLEN          = 32,
  parameter int   BHT_ENTRIES   = 64,
  parameter ctr_t CTR_INIT      = 2'b01,
  parameter int   SQUASH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_pred_taken,
  input  logic            e_valid,
  input  logic [31:0]     e_inst,
  input  logic [XLEN-1:0] e_pc,
  input  logic [XLEN-1:0] e_rs1,
  input  logic [XLEN-1:0] e_rs2,
  input  logic            e_pred_taken,
  input  logic [XLEN-1:0] e_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int SQ_W  = $clog2(SQUASH_CYCLES + 1);

  logic [4:0] opcode;
  logic [2:0] funct3;
  logic       eq, slt, ult;
  logic       ctl, is_br, taken;
  logic       active, mispredict;
  ctr_t       rd_ctr;
  fsm_state_t state;
  logic [SQ_W-1:0] sq_cnt;

  assign opcode = e_inst[6:2];
  assign funct3 = e_inst[14:12];

  assign eq  = (e_rs1 == e_rs2);
  assign slt = ($signed(e_rs1) < $signed(e_rs2));
  assign ult = (e_rs1 < e_rs2);

  // Everything outside opcode/funct3 (including bit 30) plays no part here.
  logic unused_bits;
  assign unused_bits = ^{e_inst[31:15], e_inst[11:7], e_inst[1:0],
                         f_pc[XLEN-1:IDX_W+2], f_pc[1:0], rd_ctr[0]};

  always_comb begin
    ctl   = 1'b0;
    is_br = 1'b0;
    taken = 1'b0;
    case (opcode)
      OP_BRANCH: begin
        is_br = 1'b1;
        ctl   = 1'b1;
        case (funct3)
          F3_BEQ:  taken = eq;
          F3_BNE:  taken = !eq;
          F3_BLT:  taken = slt;
          F3_BGE:  taken = !slt;
          F3_BLTU: taken = ult;
          F3_BGEU: taken = !ult;
          default: begin
            is_br = 1'b0;
            ctl   = 1'b0;
          end
        endcase
      end
      OP_JAL: begin
        ctl   = 1'b1;
        taken = 1'b1;
      end
      OP_JALR: begin
        ctl   = (funct3 == 3'b000);
        taken = ctl;
      end
      default: ;
    endcase
  end

  assign active     = e_valid && ctl && (state == ST_RUN);
  assign mispredict = active && (taken != e_pred_taken);

  bht_sat_table #(
    .DEPTH (BHT_ENTRIES),
    .INIT  (CTR_INIT),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (f_pc[IDX_W+1:2]),
    .rd_ctr   (rd_ctr),
    .wr_en    (active && is_br),
    .wr_idx   (e_pc[IDX_W+1:2]),
    .wr_taken (taken)
  );

  assign f_pred_taken = rd_ctr[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      sq_cnt      <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect <= 1'b0;
      case (state)
        ST_RUN: begin
          if (mispredict) begin
            redirect    <= 1'b1;
            redirect_pc <= taken ? e_target : e_pc + XLEN'(4);
            state       <= ST_SQUASH;
            sq_cnt      <= SQ_W'(SQUASH_CYCLES);
          end
        end
        ST_SQUASH: begin
          if (sq_cnt == SQ_W'(1)) begin
            state  <= ST_RUN;
            sq_cnt <= '0;
          end else begin
            sq_cnt <= sq_cnt - SQ_W'(1);
          end
        end
        default: begin
          state  <= ST_RUN;
          sq_cnt <= '0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (active)     stat_branches    <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
module tb_branch_predict_resolve;
  import branch_pkg::*;

  localparam int XLEN = 32;
  localparam int NENT = 64;
  localparam int SQC  = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] f_pc;
  logic            f_pred_taken;
  logic            e_valid;
  logic [31:0]     e_inst;
  logic [XLEN-1:0] e_pc, e_rs1, e_rs2, e_target;
  logic            e_pred_taken;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0]     stat_branches, stat_mispredicts;
`endif

  branch_predict_resolve #(
    .XLEN(XLEN), .BHT_ENTRIES(NENT), .CTR_INIT(2'b01), .SQUASH_CYCLES(SQC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .e_valid(e_valid), .e_inst(e_inst), .e_pc(e_pc), .e_rs1(e_rs1),
    .e_rs2(e_rs2), .e_pred_taken(e_pred_taken), .e_target(e_target),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          bht [NENT];
  bit          m_redirect;
  logic [31:0] m_rpc;
  int          m_sq;
  logic [31:0] m_br, m_mp;

  localparam logic [31:0] NOP_INST = 32'h0000_0033;  // ADD

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] f3, input bit b30);
    return {1'b0, b30, 15'h0, f3, 5'h0, op, 2'b11};
  endfunction

  // Architectural decode/resolve straight from the instruction-set rules.
  function automatic void model_eval(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                                     output bit ctl, output bit br, output bit tk);
    logic [4:0] op;
    logic [2:0] f3;
    op = inst[6:2];
    f3 = inst[14:12];
    ctl = 0; br = 0; tk = 0;
    if (op == 5'b11000 && f3 != 3'd2 && f3 != 3'd3) begin
      ctl = 1; br = 1;
      case (f3)
        3'd0: tk = (a == b);
        3'd1: tk = (a != b);
        3'd4: tk = ($signed(a) <  $signed(b));
        3'd5: tk = ($signed(a) >= $signed(b));
        3'd6: tk = (a <  b);
        default: tk = (a >= b);
      endcase
    end else if (op == 5'b11011 || (op == 5'b11001 && f3 == 3'd0)) begin
      ctl = 1; tk = 1;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NENT; i++) bht[i] = 1;
    m_redirect = 0; m_rpc = 0; m_sq = 0; m_br = 0; m_mp = 0;
  endfunction

  // One EX cycle: drive inputs at negedge, compare all outputs against the
  // model, advance the model, return just after the following posedge.
  task automatic step(input bit rst, input bit v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b, input bit pt,
                      input logic [31:0] tgt, input logic [31:0] fpc);
    bit ctl, br, tk, act;
    @(negedge clk);
    rst_n = rst; e_valid = v; e_inst = inst; e_pc = pc; e_rs1 = a; e_rs2 = b;
    e_pred_taken = pt; e_target = tgt; f_pc = fpc;
    #1;
    check("f_pred_taken", 32'(f_pred_taken), 32'(bht[idx_of(fpc)] >= 2));
    check("redirect", 32'(redirect), 32'(m_redirect));
    check("redirect_pc", redirect_pc, m_rpc);
`ifdef BRANCH_STATS_EN
    check("stat_branches", stat_branches, m_br);
    check("stat_mispredicts", stat_mispredicts, m_mp);
`endif
    if (!rst) begin
      model_reset();
    end else begin
      model_eval(inst, a, b, ctl, br, tk);
      act = v && ctl && (m_sq == 0);
      m_redirect = 0;
      if (m_sq > 0) m_sq--;
      if (act) begin
        m_br++;
        if (br) bht[idx_of(pc)] = tk ? ((bht[idx_of(pc)] < 3) ? bht[idx_of(pc)] + 1 : 3)
                                     : ((bht[idx_of(pc)] > 0) ? bht[idx_of(pc)] - 1 : 0);
        if (tk != pt) begin
          m_mp++;
          m_redirect = 1;
          m_rpc = tk ? tgt : pc + 32'd4;
          m_sq = SQC;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input logic [31:0] fpc);
    step(1, 0, NOP_INST, 0, 0, 0, 0, 0, fpc);
  endtask

  task automatic do_reset();
    step(0, 0, NOP_INST, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] inst, pc, a, b, fpc;
    logic [2:0]  f3;
    logic [2:0]  f3tab [8];
    int kind;

    f3tab[0] = 3'd0; f3tab[1] = 3'd1; f3tab[2] = 3'd4; f3tab[3] = 3'd5;
    f3tab[4] = 3'd6; f3tab[5] = 3'd7; f3tab[6] = 3'd2; f3tab[7] = 3'd3;

    rst_n = 0; e_valid = 0; e_inst = NOP_INST; e_pc = 0; e_rs1 = 0; e_rs2 = 0;
    e_pred_taken = 0; e_target = 0; f_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state: every index predicts not-taken
    nop(32'h40);
    check("pred_0x40_after_reset", 32'(f_pred_taken), 32'h0);
    for (int i = 0; i < NENT; i++) begin
      nop(32'(i) << 2);
      check("pred_all_idx_after_reset", 32'(f_pred_taken), 32'h0);
    end

    // BEQ taken, predicted not-taken
    step(1, 1, mk(OP_BRANCH, F3_BEQ, 0), 32'h100, 5, 5, 0, 32'h180, 32'h100);
    check("beq_redirect", 32'(redirect), 32'h1);
    check("beq_redirect_pc", redirect_pc, 32'h180);
    check("beq_model_bht0", 32'(bht[0]), 32'h2);
    check("beq_pred_after", 32'(f_pred_taken), 32'h1);
    nop(32'h100);

    // Signed vs unsigned compare on the same operands
    step(1, 1, mk(OP_BRANCH, F3_BLT, 1), 32'h204, 32'hFFFF_FFFF, 1, 1, 32'h500, 32'h204);
    check("blt_no_redirect", 32'(redirect), 32'h0);
    step(1, 1, mk(OP_BRANCH, F3_BLTU, 0), 32'h20C, 32'hFFFF_FFFF, 1, 1, 32'h500, 32'h20C);
    check("bltu_redirect", 32'(redirect), 32'h1);
    check("bltu_redirect_pc", redirect_pc, 32'h210);
    nop(0);

    // Saturation at 11, then one not-taken step back to 10
    for (int i = 0; i < 4; i++)
      step(1, 1, mk(OP_BRANCH, F3_BGE, 0), 32'h308, 5, 3, 1, 32'h600, 32'h308);
    check("bge_model_sat", 32'(bht[2]), 32'h3);
    check("bge_pred_sat", 32'(f_pred_taken), 32'h1);
    step(1, 1, mk(OP_BRANCH, F3_BGE, 0), 32'h308, 1, 3, 1, 32'h600, 32'h308);
    check("bge_model_dec", 32'(bht[2]), 32'h2);
    check("bge_pred_still_1", 32'(f_pred_taken), 32'h1);
    check("bge_nt_redirect_pc", redirect_pc, 32'h30C);
    nop(0);

    // JAL in the squash slot is ignored
    step(1, 1, mk(OP_BRANCH, F3_BEQ, 0), 32'h400, 7, 7, 0, 32'h480, 32'h400);
    check("sq_first_redirect", 32'(redirect), 32'h1);
    step(1, 1, mk(OP_JAL, 3'd0, 0), 32'h404, 0, 0, 0, 32'h999C, 32'h400);
    check("sq_jal_ignored", 32'(redirect), 32'h0);
    check("sq_rpc_held", redirect_pc, 32'h480);
    // Reset in the middle of a squash returns to RUN
    step(1, 1, mk(OP_BRANCH, F3_BNE, 0), 32'h410, 1, 2, 0, 32'h440, 32'h410);
    step(0, 1, mk(OP_JAL, 3'd0, 0), 32'h414, 0, 0, 0, 32'h888, 32'h410);
    check("rst_mid_squash_redirect", 32'(redirect), 32'h0);
    check("rst_mid_squash_rpc", redirect_pc, 32'h0);
    step(1, 1, mk(OP_JAL, 3'd0, 0), 32'h418, 0, 0, 0, 32'h888, 32'h410);
    check("after_rst_jal_redirect", 32'(redirect), 32'h1);
    check("after_rst_jal_rpc", redirect_pc, 32'h888);
    nop(0);

`ifdef BRANCH_STATS_EN
    do_reset();
    step(1, 1, mk(OP_BRANCH, F3_BEQ, 0), 32'h100, 1, 1, 1, 32'h200, 0);
    step(1, 1, mk(OP_BRANCH, F3_BNE, 0), 32'h104, 1, 1, 1, 32'h200, 0);
    nop(0);
    step(1, 1, mk(OP_BRANCH, F3_BLTU, 0), 32'h108, 1, 2, 1, 32'h200, 0);
    step(1, 1, NOP_INST, 32'h10C, 1, 2, 0, 32'h200, 0);
    check("stats_branches", stat_branches, 32'd3);
    check("stats_mispredicts", stat_mispredicts, 32'd1);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 5) begin
        f3 = f3tab[$urandom_range(0, 7)];
        inst = mk(OP_BRANCH, f3, 1'($urandom_range(0, 1)));
      end else if (kind == 6) inst = mk(OP_JAL, 3'($urandom_range(0, 7)), 0);
      else if (kind == 7) inst = mk(OP_JALR, ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0, 0);
      else if (kind == 8) inst = mk(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 0);
      else inst = $urandom | 32'h3;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = $urandom;
        2: b = a ^ 32'h8000_0000;
        default: b = a + 32'd1;
      endcase
      pc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : 32'h1000 + (32'($urandom_range(0, 7)) << 2);
      fpc = ($urandom_range(0, 1) == 0) ? pc : 32'h1000 + (32'($urandom_range(0, 15)) << 2);
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), inst, pc, a, b,
           1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, fpc);
    end
    nop(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
